// File: rtl/seq_alu_if.sv
// Request/result bundle between the opcode stage, the sequential ALU and the display stage.
// dbg_state mirrors the ALU state register (0 = IDLE, 1 = EXEC) for checkers.
interface seq_alu_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [3:0]           operation;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   result;
    logic                 neg;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic                 dbg_state;

    modport master (
        output start, operation, a, b,
        input  result, neg, busy, done, error, dbg_state
    );

    modport slave (
        input  start, operation, a, b,
        output result, neg, busy, done, error, dbg_state
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: add/sub finish in one edge, shift-add multiply and restoring divide in WIDTH.
// Handshake: start is sampled only in IDLE; busy is high while in EXEC; done pulses on the result-write edge.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    seq_alu_if.slave   alu_bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [3:0]        r_op;
    logic [CW-1:0]     r_cnt;
    logic [DW-1:0]     r_acc;
    logic [DW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_quo;
    logic [DW-1:0]     r_result;
    logic              r_neg;
    logic              r_error;
    logic              r_done;

    logic              w_accept;
    logic              w_is_long;
    logic              w_last;
    logic [DW-1:0]     w_acc_nxt;
    logic [WIDTH:0]    w_rem_sh;
    logic              w_fits;
    logic [WIDTH-1:0]  w_rem_diff;
    logic [WIDTH-1:0]  w_rem_nxt;
    logic [WIDTH-1:0]  w_quo_nxt;
    logic [DW-1:0]     w_res;
    logic              w_neg;
    logic              w_err;

    assign w_accept  = (r_state == IDLE) && alu_bus.start;
    // Only valid mul and non-zero-divisor div iterate; everything else completes on the first EXEC edge.
    assign w_is_long = (r_op == 4'b0100) || ((r_op == 4'b1000) && (r_b != '0));
    assign w_last    = !w_is_long || (r_cnt == CW'(WIDTH - 1));

    assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // The remainder after a successful subtract is below b, so the low WIDTH bits are exact.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_fits     = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_rem_nxt  = w_fits ? w_rem_diff : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt  = WIDTH'({r_quo, w_fits});

    always_comb begin
        w_res = '0;
        w_neg = 1'b0;
        w_err = 1'b0;
        case (r_op)
            4'b0001: w_res = DW'(r_a) + DW'(r_b);
            4'b0010: begin
                if (r_a < r_b) begin
                    w_res = DW'(r_b - r_a);
                    w_neg = 1'b1;
                end else begin
                    w_res = DW'(r_a - r_b);
                end
            end
            4'b0100: w_res = w_acc_nxt;
            4'b1000: begin
                if (r_b == '0) w_err = 1'b1;
                else           w_res = {w_rem_nxt, w_quo_nxt};
            end
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (alu_bus.start) w_state_nxt = EXEC;
            EXEC:    if (w_last)        w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_error  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a      <= alu_bus.a;
                r_b      <= alu_bus.b;
                r_op     <= alu_bus.operation;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= DW'(alu_bus.a);
                r_mplier <= alu_bus.b;
                r_rem    <= '0;
                r_quo    <= alu_bus.a;
            end else if (r_state == EXEC) begin
                if (w_last) begin
                    r_result <= w_res;
                    r_neg    <= w_neg;
                    r_error  <= w_err;
                    r_done   <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt + CW'(1);
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_nxt;
                    r_quo    <= w_quo_nxt;
                end
            end
        end
    end

    assign alu_bus.result    = r_result;
    assign alu_bus.neg       = r_neg;
    assign alu_bus.error     = r_error;
    assign alu_bus.done      = r_done;
    assign alu_bus.busy      = (r_state == EXEC);
    assign alu_bus.dbg_state = r_state;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, hand-written multi-cycle corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_seq_alu;
    localparam int W  = 4;
    localparam int DW = 2 * W;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [DW-1:0] exp_q[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .alu_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [DW-1:0] res;
        logic          neg;
        logic          err;
        int            lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic void ref_model(input logic [3:0] op, input int a, input int b,
                                      output logic [DW-1:0] res, output logic neg,
                                      output logic err, output int lat);
        int r;
        r = 0; neg = 1'b0; err = 1'b0; lat = 1;
        case (op)
            4'b0001: r = a + b;
            4'b0010: begin r = (a >= b) ? a - b : b - a; neg = (a < b); end
            4'b0100: begin r = a * b; lat = W; end
            4'b1000: begin
                if (b == 0) err = 1'b1;
                else begin r = (a % b) * (1 << W) + a / b; lat = W; end
            end
            default: err = 1'b1;
        endcase
        res = DW'(r);
    endfunction

    // Issues one request and checks latency, busy duration and completion values.
    // b2b: start is raised on the current negedge (right after a previous done).
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [DW-1:0] e_res, input logic e_neg, input logic e_err,
                          input int e_lat, input bit disturb, input bit b2b, input string name);
        int cyc;
        int busy_n;
        logic [DW-1:0] e_q;
        exp_q.push_back(e_res);
        if (!b2b) @(negedge clk);
        bus.start = 1'b1; bus.operation = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        busy_n = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_n++;
            if (disturb) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.operation = 4'($urandom);
                bus.a         = W'($urandom);
                bus.b         = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        e_q = exp_q.pop_front();
        if (!bus.done) begin
            total++; bad++;
            $display("FAIL %s timeout: no done after %0d cycles (expected latency %0d)", name, cyc, e_lat);
            return;
        end
        chk({name, " latency"}, cyc, e_lat);
        chk({name, " busy_cycles"}, busy_n, e_lat);
        chk({name, " busy_at_done"}, {31'b0, bus.busy}, 0);
        chk({name, " result"}, {24'b0, bus.result}, {24'b0, e_q});
        chk({name, " neg"}, {31'b0, bus.neg}, {31'b0, e_neg});
        chk({name, " error"}, {31'b0, bus.error}, {31'b0, e_err});
    endtask

    initial begin
        logic [DW-1:0] m_res;
        logic          m_neg;
        logic          m_err;
        int            m_lat;
        logic [3:0]    r_op;
        logic [W-1:0]  r_a;
        logic [W-1:0]  r_b;
        int            done_n;

        total = 0;
        bad = 0;
        bus.start = 1'b0; bus.operation = 4'b0000; bus.a = '0; bus.b = '0;

        vecs.push_back('{4'b0001, 4'd9,  4'd8,  8'h11, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0010, 4'd3,  4'd5,  8'h02, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0010, 4'd5,  4'd5,  8'h00, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0100, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, W});
        vecs.push_back('{4'b1000, 4'd13, 4'd4,  8'h13, 1'b0, 1'b0, W});
        vecs.push_back('{4'b1000, 4'd7,  4'd0,  8'h00, 1'b0, 1'b1, 1});
        vecs.push_back('{4'b1000, 4'd8,  4'd2,  8'h04, 1'b0, 1'b0, W});
        vecs.push_back('{4'b0110, 4'd3,  4'd2,  8'h00, 1'b0, 1'b1, 1});
        vecs.push_back('{4'b0000, 4'd3,  4'd2,  8'h00, 1'b0, 1'b1, 1});
        vecs.push_back('{4'b0010, 4'd0,  4'd15, 8'h0F, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0001, 4'd15, 4'd15, 8'h1E, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0100, 4'd0,  4'd9,  8'h00, 1'b0, 1'b0, W});
        vecs.push_back('{4'b1000, 4'd15, 4'd1,  8'h0F, 1'b0, 1'b0, W});
        vecs.push_back('{4'b1000, 4'd2,  4'd15, 8'h20, 1'b0, 1'b0, W});

        // Reset block
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset result", {24'b0, bus.result}, 0);
        chk("reset flags", {27'b0, bus.busy, bus.done, bus.error, bus.neg, bus.dbg_state}, 0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].neg, vecs[i].err,
                   vecs[i].lat, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // Multiply with operands, opcode and start churning during busy
        run_op(4'b0100, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, W, 1'b1, 1'b0, "mul_disturb");
        done_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        chk("mul_disturb extra_done", done_n, 0);
        chk("mul_disturb result_hold", {24'b0, bus.result}, 32'hE1);

        // Back-to-back: new request on the cycle done is visible
        run_op(4'b1000, 4'd13, 4'd4, 8'h13, 1'b0, 1'b0, W, 1'b0, 1'b0, "b2b_first");
        run_op(4'b0001, 4'd6, 4'd7, 8'h0D, 1'b0, 1'b0, 1, 1'b0, 1'b1, "b2b_second");
        run_op(4'b0010, 4'd2, 4'd9, 8'h07, 1'b1, 1'b0, 1, 1'b0, 1'b1, "b2b_third");

        // Reset two cycles into a multiply
        @(negedge clk);
        bus.start = 1'b1; bus.operation = 4'b0100; bus.a = 4'd15; bus.b = 4'd15;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset result", {24'b0, bus.result}, 0);
        chk("midreset flags", {27'b0, bus.busy, bus.done, bus.error, bus.neg, bus.dbg_state}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0001, 4'd1, 4'd1, 8'h02, 1'b0, 1'b0, 1, 1'b0, 1'b0, "after_reset_add");

        // Randomized operations against the reference model
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:       r_op = 4'($urandom);
                1, 2:    r_op = 4'b0001;
                3, 4:    r_op = 4'b0010;
                5, 6:    r_op = 4'b0100;
                default: r_op = 4'b1000;
            endcase
            r_a = W'($urandom_range(0, 15));
            r_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 15));
            ref_model(r_op, int'(r_a), int'(r_b), m_res, m_neg, m_err, m_lat);
            run_op(r_op, r_a, r_b, m_res, m_neg, m_err, m_lat, n[0], n[1] & n[2],
                   $sformatf("rnd%0d op=%b a=%0d b=%0d", n, r_op, r_a, r_b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Multi-cycle arithmetic unit. Sits directly downstream of the operation-select counter stage.
- Consumes the one-hot operation code from that stage plus two unsigned switch operands.
- On a start pulse, executes add, subtract, shift-add multiply or restoring divide.
- Presents a registered result with a done/busy/error handshake to the display stage.

Parameters:
WIDTH, 4, operand width in bits; result is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle request pulse from the upstream pulse generator
operation  input  4  one-hot opcode: 0001 add, 0010 sub, 0100 mul, 1000 div
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
result  output  2*WIDTH  registered result
neg  output  1  subtract result was negative (a < b)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse on the edge the result updates
error  output  1  division by zero or invalid opcode

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; result=0, neg=0, busy=0, done=0, error=0. Takes effect immediately.
- Reset mid-operation aborts the operation and discards partial results. The first edge after release is in IDLE.
- States: IDLE, EXEC.
- Accept: at edge k, if state=IDLE and start=1, latch a, b and operation, then go to EXEC.
  - busy=1 from after edge k.
  - start is ignored in EXEC; requests are not queued.
  - Later changes to a, b or operation do not affect the operation in progress.
- Latency L (edges after acceptance):
  - add, sub, invalid opcode, div-by-zero: L=1.
  - mul, div: L=WIDTH, one iteration per edge.
- At edge k+L:
  - result, neg and error are written.
  - done=1 for exactly one cycle.
  - state returns to IDLE, so busy=0.
  - busy and done are never both 1.
- A new start may be accepted on the edge immediately after done (back-to-back operation).
- Add: result = zero-extended a+b (WIDTH+1 significant bits); neg=0.
- Sub: result = zero-extended |a-b|; neg=1 iff a<b. a==b gives result=0, neg=0.
- Mul: result = a*b, computed by shift-add over WIDTH iterations (no combinational multiplier).
- Div: restoring division over WIDTH iterations; result[WIDTH-1:0]=quotient, result[2*WIDTH-1:WIDTH]=remainder.
- Div with b=0: error=1, result=0, L=1.
- Invalid opcode (any value that is not exactly one-hot, including 0000): error=1, result=0, neg=0, L=1.
- Outputs hold their values until the next completion or reset. error and neg are cleared by the next valid completion.
- done=0 in every cycle except the completion cycle.

Test Plan:
1. WIDTH=4, reset then op=0001, a=9, b=8, start pulse -> done high exactly 1 cycle after acceptance; result=17 (0x11); neg=0; busy high 1 cycle.
2. op=0010, a=3, b=5 -> result=2, neg=1, L=1. Then a=5, b=5 -> result=0, neg=0.
3. op=0100, a=15, b=15 -> busy high 4 cycles, then done with result=225 (0xE1). Toggling a, b and operation during busy leaves the result unchanged.
4. op=1000, a=13, b=4 -> after 4 cycles result=0x13 (rem 1, quot 3), error=0. Then a=7, b=0 -> error=1, result=0, L=1. Then op=1000, a=8, b=2 -> error=0, result=0x04.
5. op=0110 -> error=1, result=0, L=1. Start pulses issued while busy during a mul produce no extra done and no change to the operands in use.
6. Assert reset=0 two cycles into a mul -> result, busy, done, error, neg all 0 immediately. Release reset and start add 1+1 -> result=2 after 1 cycle.
